// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory controller: MMIO register map,
// controller state encoding and the MMIO address decode helper.
package lc3_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // True for the four device registers; every other address is RAM.
    function automatic logic is_mmio(input logic [15:0] addr);
        return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
               (addr == DSR_ADDR)  || (addr == DDR_ADDR);
    endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// Keyboard and display device registers plus their address decode.
// Build option: LC3_MMIO_EN enables the devices; without it the block
// reports no hits, ties the display outputs low and ignores the keyboard.
module lc3_mmio_regs
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] acc_addr,
    input  logic        acc_we,
    input  logic [15:0] acc_wdata,
    input  logic        acc_fire,
    output logic        mmio_hit,
    output logic [15:0] mmio_rdata,
    input  logic [7:0]  kb_data,
    input  logic        kb_valid,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    input  logic        disp_ready
);

`ifdef LC3_MMIO_EN
    logic       kb_full;
    logic       kb_ovr;
    logic [7:0] kb_byte;
    logic       kb_clr;
    logic       ddr_wr;

    assign mmio_hit = is_mmio(acc_addr);
    // KBDR read clears status on the edge entering DONE; a DDR write lands then too.
    assign kb_clr   = acc_fire && !acc_we && (acc_addr == KBDR_ADDR);
    assign ddr_wr   = acc_fire &&  acc_we && (acc_addr == DDR_ADDR);

    // Keyboard buffer: a new byte arriving with the clear wins, overrun is sticky until read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_full <= 1'b0;
            kb_ovr  <= 1'b0;
            kb_byte <= 8'h00;
        end else if (kb_clr) begin
            kb_full <= kb_valid;
            kb_ovr  <= 1'b0;
            if (kb_valid) kb_byte <= kb_data;
        end else if (kb_valid) begin
            if (kb_full) begin
                kb_ovr  <= 1'b1;
            end else begin
                kb_full <= 1'b1;
                kb_byte <= kb_data;
            end
        end
    end

    // Display output: accept a byte only when idle, release on DISP_READY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
        end else if (disp_valid) begin
            if (disp_ready) disp_valid <= 1'b0;
        end else if (ddr_wr) begin
            disp_valid <= 1'b1;
            disp_data  <= acc_wdata[7:0];
        end
    end

    // Register read mux.
    always_comb begin
        mmio_rdata = 16'h0000;
        case (acc_addr)
            KBSR_ADDR: mmio_rdata = {kb_full, kb_ovr, 14'h0000};
            KBDR_ADDR: mmio_rdata = {8'h00, kb_byte};
            DSR_ADDR:  mmio_rdata = {!disp_valid, 15'h0000};
            DDR_ADDR:  mmio_rdata = {8'h00, disp_data};
            default:   mmio_rdata = 16'h0000;
        endcase
    end
`else
    logic mmio_unused;

    assign mmio_hit    = 1'b0;
    assign mmio_rdata  = 16'h0000;
    assign disp_data   = 8'h00;
    assign disp_valid  = 1'b0;
    assign mmio_unused = ^{clk, rst_n, acc_addr, acc_we, acc_wdata, acc_fire,
                           kb_data, kb_valid, disp_ready};
`endif

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: sequences RAM accesses with WAIT_STATES wait
// cycles and routes device-register addresses to lc3_mmio_regs.
// Build option: LC3_MMIO_EN enables the keyboard/display registers.
module lc3_mem_ctrl
    import lc3_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] MAR_IN,
    input  logic [15:0] MDR_IN,
    output logic [15:0] MEM_DATA_OUT,
    output logic        R,
    output logic [15:0] RAM_ADDR,
    output logic [15:0] RAM_WDATA,
    output logic        RAM_WE,
    input  logic [15:0] RAM_RDATA,
    input  logic [7:0]  KB_DATA,
    input  logic        KB_VALID,
    output logic [7:0]  DISP_DATA,
    output logic        DISP_VALID,
    input  logic        DISP_READY
);

    localparam logic [2:0] LAST_WAIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    mem_state_t  state, nxt;
    logic [2:0]  wait_cnt;
    logic [15:0] req_addr, req_wdata;
    logic        req_we;
    logic [15:0] acc_addr, acc_wdata;
    logic        acc_we, acc_fire;
    logic        mmio_hit;
    logic [15:0] mmio_rdata;

    // In IDLE the live inputs drive the access so a zero-wait access is
    // complete by the accept edge; afterwards the latched request is used.
    assign acc_addr  = (state == IDLE) ? MAR_IN : req_addr;
    assign acc_wdata = (state == IDLE) ? MDR_IN : req_wdata;
    assign acc_we    = (state == IDLE) ? R_W    : req_we;
    assign acc_fire  = (nxt == DONE) && (state != DONE);

    assign RAM_ADDR  = acc_addr;
    assign RAM_WDATA = acc_wdata;
    assign RAM_WE    = RESET_N && acc_fire && acc_we && !mmio_hit;
    assign R         = (state == DONE);

    // Next-state: device accesses and zero-wait RAM go straight to DONE.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (MIO_EN) nxt = (mmio_hit || WAIT_STATES == 0) ? DONE : WAIT;
            WAIT: if (wait_cnt == LAST_WAIT) nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State, wait counter, request latch and read-data capture.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            wait_cnt     <= 3'd0;
            req_addr     <= 16'h0000;
            req_wdata    <= 16'h0000;
            req_we       <= 1'b0;
            MEM_DATA_OUT <= 16'h0000;
        end else begin
            state <= nxt;
            if (state == IDLE && MIO_EN) begin
                wait_cnt  <= 3'd0;
                req_addr  <= MAR_IN;
                req_wdata <= MDR_IN;
                req_we    <= R_W;
            end else if (state == WAIT) begin
                wait_cnt  <= wait_cnt + 3'd1;
            end
            if (acc_fire && !acc_we)
                MEM_DATA_OUT <= mmio_hit ? mmio_rdata : RAM_RDATA;
        end
    end

    lc3_mmio_regs u_mmio (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .acc_addr   (acc_addr),
        .acc_we     (acc_we),
        .acc_wdata  (acc_wdata),
        .acc_fire   (acc_fire),
        .mmio_hit   (mmio_hit),
        .mmio_rdata (mmio_rdata),
        .kb_data    (KB_DATA),
        .kb_valid   (KB_VALID),
        .disp_data  (DISP_DATA),
        .disp_valid (DISP_VALID),
        .disp_ready (DISP_READY)
    );

endmodule
